reg_cmd_master: RTL and testbench

Command-queueing bus master placed directly upstream of the register-control block. Accepts read/write commands over a valid/ready stream, buffers them in a small FIFO, and drives the register block's single-cycle write / next-cycle read protocol (sel, wr, addr, wdata, ready, rdata). Returns read data on a valid/ready response stream. Flags protocol violations and ready timeouts.

---
 rtl/reg_cmd_pkg.sv | 29 ++
 rtl/cmd_fifo.sv | 59 +++++
 rtl/reg_cmd_master.sv | 162 ++++++++++++++++
 tb/tb_reg_cmd_master.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_cmd_pkg.sv
// Shared types and constants for the register command master.
//   cmd_t      : one queued command {wr, addr, wdata}
//   state_t    : issue FSM states
//   CMD_ADDR_W : address width carried in cmd_t
//   CMD_DATA_W : data width carried in cmd_t
package reg_cmd_pkg;

    localparam int CMD_ADDR_W = 8;
    localparam int CMD_DATA_W = 16;

    typedef struct packed {
        logic                  wr;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    // Counter width able to hold the value 'limit' itself.
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO with registered storage and a combinational head view.
//   clk, rstn : clock, synchronous active-low reset (pointers only)
//   i_push    : write i_data (ignored while full)
//   i_data    : command to enqueue
//   i_pop     : drop the head entry (ignored while empty)
//   o_head    : current head entry
//   o_full    : no free entry
//   o_empty   : no stored entry
module cmd_fifo
    import reg_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_push,
    input  cmd_t i_data,
    input  logic i_pop,
    output cmd_t o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    cmd_t        r_mem [DEPTH];
    // Extra MSB is the wrap bit: equal pointers = empty, MSB differs = full.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_push;
    logic        w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    // Head is read combinationally so a buffered command can issue the
    // cycle after it was accepted.
    assign o_head = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/reg_cmd_master.sv
// Command-queueing master in front of the register-control block.
//   cmd_*   : command stream in (valid/ready), buffered in cmd_fifo
//   rsp_*   : read response stream out (valid/ready), held until taken
//   reg_*   : register block port (single-cycle write, next-cycle read data
//             with reg_ready low in the cycle after a read)
//   err     : sticky flag for ready-during-read-wait or ready timeout
// ADDR_WIDTH/DATA_WIDTH must match the widths carried by cmd_t.
module reg_cmd_master
    import reg_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = CMD_ADDR_W,
    parameter int DATA_WIDTH = CMD_DATA_W,
    parameter int CMD_DEPTH  = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  reg_sel,
    output logic                  reg_wr,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic                  reg_ready,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  err
);

    localparam int          TW       = cnt_width(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] CNT_ONE  = TW'(1);

    cmd_t                  w_cmd_in;
    cmd_t                  w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_rsp_free;
    logic                  w_stall;
    logic                  w_proto_err;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rsp_valid;
    logic [ADDR_WIDTH-1:0] r_rsp_addr;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_err;
    logic [TW-1:0]         r_tmo_cnt;

    // ---------------- command FIFO ----------------
    // Gating with rstn keeps cmd_ready low for the whole reset.
    assign cmd_ready = rstn & ~w_full;
    assign w_push    = cmd_valid & cmd_ready;
    assign w_cmd_in  = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};

    cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_data  (w_cmd_in),
        .i_pop   (w_issue),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ---------------- issue decision ----------------
    // A read needs the response register free by the time its data lands,
    // which is guaranteed if it is empty now or being drained this cycle.
    assign w_rsp_free  = ~r_rsp_valid | rsp_ready;
    assign w_issue     = (r_state == IDLE) & ~w_empty & reg_ready &
                         (w_head.wr | w_rsp_free);
    assign w_proto_err = (r_state == RD_WAIT) & reg_ready;
    assign w_stall     = (r_state == IDLE) & ~w_empty & ~reg_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_issue && !w_head.wr) w_state_next = RD_WAIT;
            RD_WAIT: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        reg_sel   = 1'b0;
        reg_wr    = 1'b0;
        reg_addr  = w_empty ? '0 : w_head.addr;
        reg_wdata = w_empty ? '0 : w_head.wdata;
        case (r_state)
            IDLE: begin
                reg_sel = w_issue;
                reg_wr  = w_issue & w_head.wr;
            end
            RD_WAIT: begin
                // Holding sel keeps the register block's ready recovery
                // going; if ready is already high the read is abandoned.
                reg_sel  = ~reg_ready;
                reg_addr = r_rd_addr;
            end
            default: ;
        endcase
    end

    // ---------------- read address, response, error ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_addr   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_rdata <= '0;
            r_err       <= 1'b0;
            r_tmo_cnt   <= '0;
        end else begin
            if (w_issue) r_rd_addr <= w_head.addr;

            if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
            // Capture has priority over the clear: the issue rule ensured
            // the previous response is gone by now.
            if (r_state == RD_WAIT && !reg_ready) begin
                r_rsp_valid <= 1'b1;
                r_rsp_addr  <= r_rd_addr;
                r_rsp_rdata <= reg_rdata;
            end

            // Counter saturates so a long stall cannot wrap it.
            if (w_stall) begin
                if (r_tmo_cnt != TMO_MAX) r_tmo_cnt <= r_tmo_cnt + CNT_ONE;
            end else begin
                r_tmo_cnt <= '0;
            end

            if (w_proto_err || (w_stall && r_tmo_cnt >= TMO_LAST)) r_err <= 1'b1;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_rdata = r_rsp_rdata;
    assign err       = r_err;

endmodule

// File: tb/tb_reg_cmd_master.sv
// Self-checking bench for reg_cmd_master: a transaction-level model (command
// queue, pending-read flag, response slot) plus a register-block stand-in.
module tb_reg_cmd_master;

    localparam int AW = 8, DW = 16, DEPTH = 4, TMO = 64;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid, rsp_ready = 1'b1;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_rdata;
    logic          reg_sel, reg_wr, reg_ready = 1'b0;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata, reg_rdata = '0;
    logic          err;

    always #5 clk = ~clk;

    reg_cmd_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
        .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_ready(reg_ready), .reg_rdata(reg_rdata),
        .err(err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          wr;
        bit [AW-1:0] addr;
        bit [DW-1:0] wdata;
    } mcmd_t;

    mcmd_t       q[$];
    bit          m_rd_pend;
    bit [AW-1:0] m_rd_addr;
    bit          m_rsp_v;
    bit [AW-1:0] m_rsp_a;
    bit [DW-1:0] m_rsp_d;
    bit          m_err;
    int          m_stall;
    bit          m_issue;

    // ---------------- register block stand-in ----------------
    bit [DW-1:0] regmem [256];
    bit          env_rd;
    bit [AW-1:0] env_rd_addr;
    int          stall_pct = 0;
    bit          force_low = 0;
    bit          force_proto = 0;

    task automatic model_reset();
        q.delete();
        m_rd_pend = 0; m_rd_addr = '0;
        m_rsp_v = 0; m_rsp_a = '0; m_rsp_d = '0;
        m_err = 0; m_stall = 0; m_issue = 0;
    endtask

    // Compare every meaningful DUT output against the model for this cycle.
    task automatic compare();
        bit e_sel, e_wr;
        if (m_rd_pend) begin
            m_issue = 0;
            e_sel   = !reg_ready;
            e_wr    = 0;
        end else begin
            m_issue = (q.size() > 0) && reg_ready && (q[0].wr || !m_rsp_v || rsp_ready);
            e_sel   = m_issue;
            e_wr    = m_issue && q[0].wr;
        end
        chk("cmd_ready", cmd_ready, q.size() < DEPTH);
        chk("reg_sel", reg_sel, e_sel);
        chk("reg_wr", reg_wr, e_wr);
        chk("rsp_valid", rsp_valid, m_rsp_v);
        chk("err", err, m_err);
        if (m_issue) begin
            chk("reg_addr", reg_addr, q[0].addr);
            if (q[0].wr) chk("reg_wdata", reg_wdata, q[0].wdata);
        end
        if (m_rsp_v) begin
            chk("rsp_addr", rsp_addr, m_rsp_a);
            chk("rsp_rdata", rsp_rdata, m_rsp_d);
        end
    endtask

    // Drive the register block's response for this cycle, then check.
    task automatic settle();
        if (env_rd) begin
            reg_ready = force_proto;
            reg_rdata = regmem[env_rd_addr];
        end else begin
            reg_ready = force_low ? 1'b0 : ($urandom_range(99) >= stall_pct);
            reg_rdata = DW'($urandom);
        end
        #1;
        if (rstn) compare();
        else      chk("cmd_ready_in_reset", cmd_ready, 0);
    endtask

    // Update register stand-in and model with this cycle's events, then clock.
    task automatic advance();
        bit accept;
        if (rstn && reg_sel && reg_wr && reg_ready) regmem[reg_addr] = reg_wdata;
        env_rd      = rstn && reg_sel && !reg_wr && reg_ready;
        env_rd_addr = reg_addr;
        if (!rstn) begin
            model_reset();
        end else begin
            accept = cmd_valid && (q.size() < DEPTH);
            if (m_rsp_v && rsp_ready) m_rsp_v = 0;
            if (m_rd_pend) begin
                if (reg_ready) m_err = 1;
                else begin
                    m_rsp_v = 1; m_rsp_a = m_rd_addr; m_rsp_d = reg_rdata;
                end
            end
            if (!m_rd_pend && q.size() > 0 && !reg_ready) begin
                m_stall++;
                if (m_stall >= TMO) m_err = 1;
            end else begin
                m_stall = 0;
            end
            if (m_issue) begin
                m_rd_pend = !q[0].wr;
                m_rd_addr = q[0].addr;
                void'(q.pop_front());
            end else begin
                m_rd_pend = 0;
            end
            if (accept) q.push_back('{cmd_wr, cmd_addr, cmd_wdata});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic offer(input bit wr, input bit [AW-1:0] a, input bit [DW-1:0] d);
        cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
    endtask

    task automatic do_reset();
        rstn = 0; cmd_valid = 0;
        cyc(); cyc();
        rstn = 1;
    endtask

    initial begin
        bit acc;
        model_reset();
        for (int i = 0; i < 256; i++) regmem[i] = DW'($urandom);
        do_reset();

        // ---- reset values ----
        settle();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_reg_sel", reg_sel, 0);
        chk("rst_reg_wr", reg_wr, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_err", err, 0);
        advance();

        // ---- single read of 0x10 ----
        regmem[8'h10] = 16'h1234;
        offer(0, 8'h10, 16'h0); cyc();
        cmd_valid = 0;
        settle(); chk("rd10_issue_sel", reg_sel, 1); chk("rd10_issue_addr", reg_addr, 8'h10); advance();
        settle(); chk("rd10_wait_sel", reg_sel, 1); chk("rd10_wait_rspv", rsp_valid, 0); advance();
        settle();
        chk("rd10_rspv", rsp_valid, 1);
        chk("rd10_rdata", rsp_rdata, 16'h1234);
        chk("rd10_raddr", rsp_addr, 8'h10);
        advance();

        // ---- write 0x22 <- 0xBEEF, then read it back ----
        offer(1, 8'h22, 16'hBEEF); cyc();
        offer(0, 8'h22, 16'h0);
        settle();
        chk("wr22_sel", reg_sel, 1); chk("wr22_wr", reg_wr, 1);
        chk("wr22_addr", reg_addr, 8'h22); chk("wr22_wdata", reg_wdata, 16'hBEEF);
        advance();
        cmd_valid = 0;
        settle(); chk("rd22_issue_wr", reg_wr, 0); advance();
        settle(); chk("rd22_wait_sel", reg_sel, 1); advance();
        settle(); chk("rd22_rdata", rsp_rdata, 16'hBEEF); advance();

        // ---- five commands, FIFO fills while stalled ----
        force_low = 1;
        for (int i = 0; i < 4; i++) begin
            offer(1, AW'(8'h30 + i), DW'(16'hA000 + i)); cyc();
        end
        offer(0, 8'h30, 16'h0);
        force_low = 0;
        settle(); chk("fifo_full_cmd_ready", cmd_ready, 0); advance();
        acc = 0;
        for (int k = 0; k < 10 && !acc; k++) begin
            settle(); acc = cmd_ready; advance();
        end
        chk("push5_accept", acc, 1);
        cmd_valid = 0;
        acc = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            settle(); acc = rsp_valid; if (acc) chk("push5_rdata", rsp_rdata, 16'hA000); advance();
        end
        chk("push5_rsp_seen", acc, 1);

        // ---- two reads with back-pressure on the response ----
        regmem[8'h40] = 16'h4040; regmem[8'h41] = 16'h4141;
        rsp_ready = 0;
        offer(0, 8'h40, 16'h0); cyc();
        offer(0, 8'h41, 16'h0); cyc();
        cmd_valid = 0;
        for (int k = 0; k < 8; k++) cyc();
        settle();
        chk("bp_rspv", rsp_valid, 1); chk("bp_addr", rsp_addr, 8'h40);
        chk("bp_rdata", rsp_rdata, 16'h4040); chk("bp_no_issue", reg_sel, 0);
        advance();
        rsp_ready = 1; cyc();
        rsp_ready = 0; cyc(); cyc();
        settle(); chk("bp2_addr", rsp_addr, 8'h41); chk("bp2_rdata", rsp_rdata, 16'h4141); advance();
        rsp_ready = 1; cyc();

        // ---- ready timeout ----
        force_low = 1;
        offer(1, 8'h50, 16'h5555); cyc();
        cmd_valid = 0;
        for (int k = 1; k <= TMO; k++) begin
            settle(); chk("tmo_err_low", err, 0); advance();
        end
        settle(); chk("tmo_err_set", err, 1); advance();
        force_low = 0;
        for (int k = 0; k < 5; k++) cyc();
        settle(); chk("tmo_err_sticky", err, 1); advance();
        do_reset();
        settle(); chk("tmo_err_cleared", err, 0); advance();

        // ---- reset during read wait ----
        offer(0, 8'h60, 16'h0); cyc();
        cmd_valid = 0;
        cyc();
        rstn = 0; cyc();
        rstn = 1;
        settle();
        chk("rstrd_rspv", rsp_valid, 0); chk("rstrd_sel", reg_sel, 0);
        chk("rstrd_cmd_ready", cmd_ready, 1); chk("rstrd_err", err, 0);
        advance();
        for (int k = 0; k < 3; k++) cyc();

        // ---- ready high during read wait ----
        offer(0, 8'h70, 16'h0); cyc();
        cmd_valid = 0;
        cyc();
        force_proto = 1;
        settle(); chk("proto_sel", reg_sel, 0); advance();
        force_proto = 0;
        settle(); chk("proto_err", err, 1); chk("proto_no_rsp", rsp_valid, 0); advance();
        do_reset();

        // ---- randomized traffic ----
        stall_pct = 10;
        for (int n = 0; n < 1500; n++) begin
            cmd_valid = ($urandom_range(99) < 60);
            cmd_wr    = $urandom_range(1);
            cmd_addr  = AW'($urandom);
            cmd_wdata = DW'($urandom);
            rsp_ready = ($urandom_range(99) < 70);
            cyc();
        end
        cmd_valid = 0; rsp_ready = 1; stall_pct = 0;
        for (int k = 0; k < 20; k++) cyc();
        settle(); chk("drain_empty", cmd_ready, 1); chk("drain_rspv", rsp_valid, 0); advance();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
